seg7_display_arbiter: RTL
=========================

# seg7_display_arbiter

Shares the 4-digit 7-segment display between two independent requesters, A and B, for example a counter datapath and a debug source. It grants ownership through a request/grant handshake with round-robin fairness and a minimum hold time, so the display does not flicker when both sources contend. It forwards the owner's 16-bit hex value to the multiplexed display scanner. It also generates the scanner's digit-advance strobe from a prescaler.

## Interface
Parameters:
- HOLD_CYCLES, 1000: minimum ownership in cycles before a contending requester may take over; legal range ≥ 2.
- SCAN_DIV, 50000: period of scan_tick in cycles; legal range ≥ 2.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A wants the display; level, held while it wants ownership.
- data_a  in  16  A's value, 4 hex nibbles; nibble [3:0] is the lowest digit.
- grant_a  out  1  A owns the display.
- req_b  in  1  same as req_a, for requester B.
- data_b  in  16  same as data_a, for requester B.
- grant_b  out  1  same as grant_a, for requester B.
- disp_data  out  16  value driven to the scanner.
- disp_valid  out  1  an owner exists (state ≠ IDLE).
- owner  out  1  0 = A, 1 = B; holds the last owner while IDLE.
- scan_tick  out  1  one-cycle strobe; the scanner advances one digit per strobe.

## Operation
States:
- IDLE
- OWN_A
- OWN_B

Registers:
- hold_cnt: width $clog2(HOLD_CYCLES). Clears to 0 on every grant. Increments each owned cycle and saturates at HOLD_CYCLES-1. "Expired" means hold_cnt == HOLD_CYCLES-1.
- last: the previous owner. Resets to B, so A wins the first tie.

Transitions, evaluated at each edge:
- IDLE, one requester active: move to that requester's OWN state.
- IDLE, both active: grant the requester that is not `last`.
- IDLE, neither active: stay in IDLE.
- OWN_X, own req dropped, other requester active: go directly to OWN_other (zero idle cycles).
- OWN_X, own req dropped, other requester inactive: go to IDLE. Voluntary release is allowed before expiry.
- OWN_X, own req held, other requester active, hold expired: go to OWN_other (time-slice).
- OWN_X, own req held, hold not expired or other inactive: stay in OWN_X.

Outputs and registers, all registered:
- grant_a = (state == OWN_A); grant_b = (state == OWN_B); never both high.
- Every edge that ends in OWN_X, including the granting edge, loads disp_data <= data_X. Value changes from the owner are therefore tracked live with 1-cycle latency.
- owner and last update on each grant.

Prescaler:
- scan_cnt counts 0..SCAN_DIV-1 and wraps.
- scan_tick is registered high for the one cycle following the edge where scan_cnt == SCAN_DIV-1.
- The prescaler is free-running and unaffected by arbitration.

Reset:
- Values: state IDLE, hold_cnt 0, last B, scan_cnt 0.
- Outputs: grant_a/grant_b 0, disp_data 16'h0000, disp_valid 0, owner 0, scan_tick 0.
- Reset asserted mid-ownership drops the grant immediately (asynchronous). After release, arbitration restarts from IDLE with A favoured.

## Timing
- req to grant: 1 cycle when uncontended (req sampled at edge n; grant high after edge n).
- data_X to disp_data: 1 cycle while X owns the display.
- req drop to grant low: 1 cycle.
- Contended handover: the owner holds exactly HOLD_CYCLES cycles, then the other grant rises on the next edge and the old grant falls on that same edge. There is no gap and no overlap.
- Simultaneous drop by the owner and request by the other is resolved as a direct handover in 1 cycle.
- scan_tick period: exactly SCAN_DIV cycles. The first pulse is high during cycle SCAN_DIV after reset release.

## Configuration
- SEG7_ARB_KEEP_LAST_EN defined: in IDLE, disp_data keeps the last owner's value, so the display freezes.
- Not defined: the edge entering IDLE loads disp_data <= 16'h0000, and disp_data stays 0 throughout IDLE.
- disp_valid, owner and grant behaviour are identical in both builds.

## Test plan
Parameters: HOLD_CYCLES=4, SCAN_DIV=3.
- Reset then idle. Expect: all outputs 0; scan_tick high on cycles 3, 6, 9 after release.
- req_a=1, data_a=16'h1234. Expect: grant_a=1 and disp_data=16'h1234 one cycle later. Then data_a=16'hBEEF; expect disp_data=16'hBEEF one cycle later.
- req_a and req_b rise on the same edge out of reset. Expect: grant_a first. After 4 owned cycles, grant_b=1 and owner=1 with no gap. After 4 more, back to A.
- A owns, drops req_a at hold_cnt=1, req_b=0. Expect: IDLE next cycle, disp_valid=0. disp_data is 16'h0000 without the macro; with it, disp_data holds the last A value.
- A owns, req_a falls on the edge where req_b rises. Expect: grant_b one cycle later, grant_a low on the same edge, no overlap.
- Assert rst while OWN_B. Expect: grant_b=0 and disp_data=0 immediately, without waiting for a clock edge. After release with both requesting, A is granted.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Two-requester round-robin arbiter for a shared 4-digit 7-segment display, plus scan prescaler.
// Define SEG7_ARB_KEEP_LAST_EN to freeze the last owner's value on the display while idle.
module seg7_display_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int SCAN_DIV    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    output logic        grant_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        grant_b,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic        owner,
    output logic        scan_tick
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            last_q, last_d;       // 1 = B
    logic            owner_q, owner_d;
    logic [15:0]     disp_q, disp_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic            scan_tick_q, scan_tick_d;
    logic            expired;

    assign expired = (hold_cnt_q == HOLD_MAX);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        disp_d      = disp_q;

        case (state_q)
            IDLE: begin
                // On a tie, the requester that did not own last goes first.
                if (req_a && (!req_b || last_q)) state_d = OWN_A;
                else if (req_b)                  state_d = OWN_B;
            end
            OWN_A: begin
                if (!req_a)                 state_d = req_b ? OWN_B : IDLE;
                else if (req_b && expired)  state_d = OWN_B;
            end
            OWN_B: begin
                if (!req_b)                 state_d = req_a ? OWN_A : IDLE;
                else if (req_a && expired)  state_d = OWN_A;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE || state_d != state_q) hold_cnt_d = '0;
        else if (!expired)                         hold_cnt_d = hold_cnt_q + 1'b1;

        if (state_d != IDLE && state_d != state_q) begin
            owner_d = (state_d == OWN_B);
            last_d  = (state_d == OWN_B);
        end

        case (state_d)
            OWN_A:   disp_d = data_a;
            OWN_B:   disp_d = data_b;
`ifdef SEG7_ARB_KEEP_LAST_EN
            default: disp_d = disp_q;
`else
            default: disp_d = 16'h0000;
`endif
        endcase
    end

    // Free-running prescaler, independent of arbitration.
    always_comb begin
        scan_tick_d = (scan_cnt_q == SCAN_MAX);
        scan_cnt_d  = scan_tick_d ? '0 : scan_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            disp_q      <= 16'h0000;
            scan_cnt_q  <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            disp_q      <= disp_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign grant_a    = (state_q == OWN_A);
    assign grant_b    = (state_q == OWN_B);
    assign disp_valid = (state_q != IDLE);
    assign disp_data  = disp_q;
    assign owner      = owner_q;
    assign scan_tick  = scan_tick_q;

endmodule
